// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared definitions for the two-requester round-robin arbiter:
// FSM state encoding, burst counter width and statistics counter width.
package mux2_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_G0   = 2'd1,
        ST_G1   = 2'd2
    } state_t;

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned STAT_W = 16;

endpackage

// File: rtl/mux2_w.sv
// WIDTH-parameterised 2:1 multiplexer (sel=0 -> in0, sel=1 -> in1).
module mux2_w #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic [WIDTH-1:0] out
);

    // Pure select; no masking here.
    always_comb begin
        out = sel ? in1 : in0;
    end

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter sharing one 2:1 datapath mux between two requesters.
// Grants a requester for at most BURST accepted beats, then re-arbitrates;
// hands over to the other requester with no idle bubble when it is waiting.
// Optional per-requester accepted-beat counters (stat0/stat1) are enabled
// by defining MUX2_ARB_STATS_EN.
module mux2_rr_arbiter
    import mux2_rr_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [WIDTH-1:0]  data0,
    output logic              ack0,
    input  logic              req1,
    input  logic [WIDTH-1:0]  data1,
    output logic              ack1,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
`ifdef MUX2_ARB_STATS_EN
    output logic [STAT_W-1:0] stat0,
    output logic [STAT_W-1:0] stat1,
`endif
    output logic              out_sel
);

    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST - 1);

    state_t           state;
    logic             last;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] mux_out;

    // Grant-qualified handshake signals derived from registered state only.
    always_comb begin
        out_sel   = (state == ST_G1);
        out_valid = ((state == ST_G0) && req0) || ((state == ST_G1) && req1);
        ack0      = (state == ST_G0) && req0 && out_ready;
        ack1      = (state == ST_G1) && req1 && out_ready;
    end

    mux2_w #(
        .WIDTH (WIDTH)
    ) u_mux (
        .sel (out_sel),
        .in0 (data0),
        .in1 (data1),
        .out (mux_out)
    );

    // Data is forced to zero whenever no beat is being presented.
    always_comb begin
        out_data = out_valid ? mux_out : '0;
    end

    // Arbitration FSM: grant selection, burst counting and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            last  <= 1'b1;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req0 && (!req1 || last)) begin
                        state <= ST_G0;
                    end else if (req1) begin
                        state <= ST_G1;
                    end
                end
                ST_G0: begin
                    // Request drop and burst completion collapse into one exit.
                    if (!req0 || (ack0 && (cnt == BURST_LAST))) begin
                        last  <= 1'b0;
                        cnt   <= '0;
                        state <= req1 ? ST_G1 : ST_IDLE;
                    end else if (ack0) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_G1: begin
                    if (!req1 || (ack1 && (cnt == BURST_LAST))) begin
                        last  <= 1'b1;
                        cnt   <= '0;
                        state <= req0 ? ST_G0 : ST_IDLE;
                    end else if (ack1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef MUX2_ARB_STATS_EN
    // Saturating per-requester counts of accepted beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat0 <= '0;
            stat1 <= '0;
        end else begin
            if (ack0 && (stat0 != '1)) begin
                stat0 <= stat0 + 1'b1;
            end
            if (ack1 && (stat1 != '1)) begin
                stat1 <= stat1 + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed self-checking bench for mux2_rr_arbiter (BURST=4 and BURST=1).
// Stats outputs are checked only when MUX2_ARB_STATS_EN is defined.
module tb_mux2_rr_arbiter;

    logic       clk;
    logic       rst;
    logic       req0;
    logic       req1;
    logic [7:0] data0;
    logic [7:0] data1;
    logic       out_ready;

    logic       ack0, ack1, out_valid, out_sel;
    logic [7:0] out_data;
    logic       b_ack0, b_ack1, b_valid, b_sel;
    logic [7:0] b_data;
`ifdef MUX2_ARB_STATS_EN
    logic [15:0] stat0, stat1, b_stat0, b_stat1;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    mux2_rr_arbiter #(
        .WIDTH (8),
        .BURST (4)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .data0     (data0),
        .ack0      (ack0),
        .req1      (req1),
        .data1     (data1),
        .ack1      (ack1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef MUX2_ARB_STATS_EN
        .stat0     (stat0),
        .stat1     (stat1),
`endif
        .out_sel   (out_sel)
    );

    mux2_rr_arbiter #(
        .WIDTH (8),
        .BURST (1)
    ) u_dut_b1 (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .data0     (data0),
        .ack0      (b_ack0),
        .req1      (req1),
        .data1     (data1),
        .ack1      (b_ack1),
        .out_valid (b_valid),
        .out_ready (out_ready),
        .out_data  (b_data),
`ifdef MUX2_ARB_STATS_EN
        .stat0     (b_stat0),
        .stat1     (b_stat1),
`endif
        .out_sel   (b_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic es, ev, ea0, ea1, bs;
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        data0 = '0; data1 = '0; out_ready = 1'b0;

        // Reset then idle.
        do_reset();
        out_ready = 1'b1;
        #2;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_sel",   32'(out_sel),   32'd0);
        check("rst_data",  32'(out_data),  32'd0);
        check("rst_ack0",  32'(ack0),      32'd0);
        check("rst_ack1",  32'(ack1),      32'd0);
`ifdef MUX2_ARB_STATS_EN
        check("rst_stat0", 32'(stat0), 32'd0);
        check("rst_stat1", 32'(stat1), 32'd0);
`endif
        next_cycle();
        check("idle_valid", 32'(out_valid), 32'd0);

        // Single requester: beats on 1..4, idle on 5, granted again on 6.
        do_reset();
        req0 = 1'b1; data0 = 8'hA5; out_ready = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            #2;
            ev = (c >= 1 && c <= 4) || (c == 6);
            check("single_valid", 32'(out_valid), 32'(ev));
            check("single_ack0",  32'(ack0),      32'(ev));
            check("single_ack1",  32'(ack1),      32'd0);
            check("single_data",  32'(out_data),  ev ? 32'hA5 : 32'h0);
            next_cycle();
        end
        req0 = 1'b0;
        #2;
        check("single_drop_valid", 32'(out_valid), 32'd0);
`ifdef MUX2_ARB_STATS_EN
        check("single_stat0", 32'(stat0), 32'd5);
`endif
        next_cycle();

        // Fairness: both requesting; BURST=4 blocks and BURST=1 alternation.
        do_reset();
        req0 = 1'b1; req1 = 1'b1; data0 = 8'h11; data1 = 8'h22; out_ready = 1'b1;
        for (int c = 0; c <= 12; c++) begin
            #2;
            if (c == 0) begin
                check("fair_c0_valid",   32'(out_valid), 32'd0);
                check("fair_c0_b_valid", 32'(b_valid),   32'd0);
            end else begin
                es = (((c - 1) / 4) % 2) == 1;
                check("fair_sel",  32'(out_sel),  32'(es));
                check("fair_ack0", 32'(ack0),     32'(!es));
                check("fair_ack1", 32'(ack1),     32'(es));
                check("fair_data", 32'(out_data), es ? 32'h22 : 32'h11);
                bs = ((c - 1) % 2) == 1;
                check("b1_sel",  32'(b_sel),  32'(bs));
                check("b1_ack0", 32'(b_ack0), 32'(!bs));
                check("b1_ack1", 32'(b_ack1), 32'(bs));
            end
            next_cycle();
        end

        // Backpressure on G1: stall cycles 2..4 must not count beats.
        do_reset();
        req0 = 1'b0; req1 = 1'b1; data1 = 8'h3C;
        for (int c = 0; c <= 8; c++) begin
            out_ready = !(c >= 2 && c <= 4);
            #2;
            ev  = (c >= 1 && c <= 7);
            ea1 = (c == 1) || (c >= 5 && c <= 7);
            check("bp_valid", 32'(out_valid), 32'(ev));
            check("bp_sel",   32'(out_sel),   32'(ev));
            check("bp_ack1",  32'(ack1),      32'(ea1));
            next_cycle();
        end

        // Early release in G0 after 2 beats; requester 1 then gets a full burst.
        do_reset();
        req0 = 1'b1; req1 = 1'b1; data0 = 8'h5A; data1 = 8'hC3; out_ready = 1'b1;
        for (int c = 0; c <= 8; c++) begin
            req0 = (c != 3);
            #2;
            es  = (c >= 4 && c <= 7);
            ea0 = (c == 1) || (c == 2) || (c == 8);
            check("early_sel",  32'(out_sel), 32'(es));
            check("early_ack0", 32'(ack0),    32'(ea0));
            check("early_ack1", 32'(ack1),    32'(es));
            next_cycle();
        end

        // Reset mid-burst in G1 after 2 beats.
        do_reset();
        req0 = 1'b0; req1 = 1'b1; data1 = 8'h77; out_ready = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            rst = (c == 3);
            #2;
            ev = (c >= 1 && c <= 3) || (c >= 5 && c <= 8) || (c == 10);
            check("mrst_valid", 32'(out_valid), 32'(ev));
            check("mrst_ack1",  32'(ack1),      32'(ev));
`ifdef MUX2_ARB_STATS_EN
            if (c == 4) begin
                check("mrst_stat0", 32'(stat0), 32'd0);
                check("mrst_stat1", 32'(stat1), 32'd0);
            end
`endif
            next_cycle();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mux2_rr_arbiter.md
Name: mux2_rr_arbiter

Overview:
- Round-robin arbiter that shares one 2:1 datapath mux between two requesters, each with a valid/ready-style request.
- Owns the mux select. It grants one requester at a time for a bounded burst of beats, then forwards that requester's data to a single downstream consumer.
- Sits between two producer blocks and one shared consumer.
- Replaces hand-driven select lines with a sequenced, fair controller.

Parameters:
- WIDTH, 8, data width of each requester and of the output.
- BURST, 4, maximum beats transferred per grant before the arbiter must re-arbitrate (legal range 1..255).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req0  input  1  requester 0 has a beat to send.
- data0  input  WIDTH  requester 0 beat data; stable while req0=1 and not acked.
- ack0  output  1  requester 0 beat accepted this cycle.
- req1  input  1  requester 1 has a beat to send.
- data1  input  WIDTH  requester 1 beat data; stable while req1=1 and not acked.
- ack1  output  1  requester 1 beat accepted this cycle.
- out_valid  output  1  out_data holds a valid beat.
- out_ready  input  1  downstream accepts the beat when out_valid=1.
- out_data  output  WIDTH  muxed data of the granted requester.
- out_sel  output  1  current mux select (0 = requester 0, 1 = requester 1).

Behaviour:
- State machine states: IDLE, G0, G1. Registered state, round-robin pointer last (1 bit), beat counter cnt (8 bits).
- Reset values:
  - state=IDLE, last=1 (requester 0 wins the first tie), cnt=0.
  - out_valid=0, ack0=ack1=0, out_sel=0, out_data=0.
- Outputs, all combinational from registered state:
  - out_sel=1 only in G1.
  - out_valid = (G0 & req0) | (G1 & req1).
  - out_data = out_sel ? data1 : data0 when out_valid, else 0.
  - ack0 = G0 & req0 & out_ready; ack1 = G1 & req1 & out_ready.
- IDLE transitions:
  - Only req0 -> G0.
  - Only req1 -> G1.
  - Both -> G0 if last=1, else G1.
  - Neither -> stay.
- Latency: req rising in IDLE gives out_valid on the next cycle (1-cycle grant latency). There is no combinational path from req to grant.
- In Gn, an ack (ackn=1) increments cnt.
- Leaving Gn happens in either case:
  - (a) reqn=0.
  - (b) ackn=1 and cnt==BURST-1.
- On leaving Gn: last<=n, cnt<=0. Next state is G(other) if the other requester's req is 1 in that cycle, else IDLE. This gives zero-bubble handover.
- Both (a) and (b) true in the same cycle: treat as a single exit.
- BURST=1: every acked beat forces re-arbitration.
- out_ready=0 while granted: hold the grant, cnt unchanged, no ack. No timeout; the grant is held until the exit conditions are met.
- Requester dropping req mid-burst: exit on that cycle. No beat is counted for that cycle.
- rst asserted mid-burst: the next edge returns everything to reset values. An in-flight unacked beat is discarded; the requester must re-present it.
- Fairness: with both requesting continuously and out_ready=1, grants alternate in blocks of BURST beats.

Optional Feature:
- Macro: MUX2_ARB_STATS_EN.
- Defined:
  - Adds outputs stat0 and stat1 (16 bits each).
  - Each counts accepted beats per requester and saturates at 16'hFFFF.
  - Both clear on rst.
- Undefined: ports and counters are absent. Core behaviour is identical.

Decomposition:
- Shared package holds:
  - State encoding constants ST_IDLE=2'd0, ST_G0=2'd1, ST_G1=2'd2.
  - Counter width constant CNT_W=8.
  - Stats width STAT_W=16.
- One natural sub-module: mux2_w, a WIDTH-parameterised 2:1 mux (select, in0, in1 -> out).
  - The arbiter instantiates it for out_data.
  - Masking to 0 when out_valid=0 is applied outside it.

Test Plan:
- Reset then idle (BURST=4): rst=1 for 2 cycles, no reqs -> out_valid=0, out_sel=0, out_data=0, ack0=ack1=0.
- Single requester: req0=1 with data0=8'hA5 and out_ready=1 from cycle 0.
  - Cycle 1: out_valid=1, out_data=8'hA5, ack0=1.
  - Beats on cycles 1..4, then one IDLE cycle, then G0 again.
- Both requesting continuously, out_ready=1, BURST=4:
  - ack0 on 4 cycles, then ack1 on the next 4 with no gap.
  - out_sel toggles every 4 cycles; the first grant goes to requester 0.
- Backpressure: G1 active, out_ready=0 for 3 cycles -> ack1=0, out_sel=1 held, cnt unchanged; on out_ready=1, ack1=1.
- Early release: in G0 after 2 beats, req0 drops while req1=1 -> next cycle out_sel=1. Then both request again: requester 1 gets a full 4 beats before requester 0.
- Reset mid-burst: rst=1 during G1 after 2 beats -> next cycle state IDLE, out_valid=0. With MUX2_ARB_STATS_EN defined, stat0=stat1=0.
